// File: rtl/sy_ppl_gpr_wb_arb.sv
// ----------------------------------------------------------------------------
// sy_ppl_gpr_wb_arb
//
// Writeback arbiter that merges two long-latency result streams (MDU and FPU)
// into the single register-file write port. Each source has its own small
// FIFO. A round-robin arbiter pops at most one head per cycle, and the granted
// entry is registered onto the write port, so the write appears two cycles
// after the push at the earliest.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-low reset
//   flush_i                  drop every queued result, suppress next write
//   mdu_wb_valid_i/ready_o   MDU result handshake
//   mdu_wb_idx_i/data_i      MDU destination physical register and data
//   fpu_wb_valid_i/ready_o   FPU result handshake
//   fpu_wb_idx_i/data_i      FPU destination physical register and data
//   gpr_wr_en_o              register-file write enable (one write per cycle)
//   gpr_wr_idx_o             register-file write index (held when idle)
//   gpr_wr_data_o            register-file write data  (held when idle)
// ----------------------------------------------------------------------------
module sy_ppl_gpr_wb_arb #(
    parameter int unsigned DWTH        = 64,
    parameter int unsigned PHY_REG_WTH = 7,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,

    input  logic                   mdu_wb_valid_i,
    output logic                   mdu_wb_ready_o,
    input  logic [PHY_REG_WTH-1:0] mdu_wb_idx_i,
    input  logic [DWTH-1:0]        mdu_wb_data_i,

    input  logic                   fpu_wb_valid_i,
    output logic                   fpu_wb_ready_o,
    input  logic [PHY_REG_WTH-1:0] fpu_wb_idx_i,
    input  logic [DWTH-1:0]        fpu_wb_data_i,

    output logic                   gpr_wr_en_o,
    output logic [PHY_REG_WTH-1:0] gpr_wr_idx_o,
    output logic [DWTH-1:0]        gpr_wr_data_o
);

    localparam int unsigned PTR_WTH = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_WTH = PTR_WTH + 1;
    localparam logic [CNT_WTH-1:0] CNT_FULL = CNT_WTH'(FIFO_DEPTH);

    // Channel 0 is the MDU, channel 1 is the FPU.
    logic [1:0]             in_valid;
    logic [PHY_REG_WTH-1:0] in_idx  [2];
    logic [DWTH-1:0]        in_data [2];

    logic [PHY_REG_WTH-1:0] mem_idx  [2][FIFO_DEPTH];
    logic [DWTH-1:0]        mem_data [2][FIFO_DEPTH];

    logic [PTR_WTH-1:0]     rptr_q [2];
    logic [PTR_WTH-1:0]     rptr_d [2];
    logic [PTR_WTH-1:0]     wptr_q [2];
    logic [PTR_WTH-1:0]     wptr_d [2];
    logic [CNT_WTH-1:0]     cnt_q  [2];
    logic [CNT_WTH-1:0]     cnt_d  [2];

    logic [1:0]             ready;
    logic [1:0]             push;
    logic [1:0]             not_empty;
    logic [1:0]             grant;
    logic                   sel;

    // Set when the MDU wins the next tie; cleared after an MDU grant.
    logic                   mdu_pri_q;
    logic                   mdu_pri_d;

    logic                   wr_en_q;
    logic                   wr_en_d;
    logic [PHY_REG_WTH-1:0] wr_idx_q;
    logic [PHY_REG_WTH-1:0] wr_idx_d;
    logic [DWTH-1:0]        wr_data_q;
    logic [DWTH-1:0]        wr_data_d;

    assign in_valid   = {fpu_wb_valid_i, mdu_wb_valid_i};
    assign in_idx[0]  = mdu_wb_idx_i;
    assign in_idx[1]  = fpu_wb_idx_i;
    assign in_data[0] = mdu_wb_data_i;
    assign in_data[1] = fpu_wb_data_i;

    // Ready looks only at the registered count, so a pop in the same cycle
    // never opens a full queue. Writes to x0 are handshaken but dropped.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            ready[c]     = (cnt_q[c] < CNT_FULL) && !flush_i;
            push[c]      = in_valid[c] && ready[c] && (in_idx[c] != '0);
            not_empty[c] = (cnt_q[c] != '0);
        end
    end

    assign mdu_wb_ready_o = ready[0];
    assign fpu_wb_ready_o = ready[1];

    // Round-robin grant; nothing is granted in a flush cycle.
    always_comb begin
        grant = 2'b00;
        if (!flush_i) begin
            if (not_empty == 2'b11) begin
                grant = mdu_pri_q ? 2'b01 : 2'b10;
            end else begin
                grant = not_empty;
            end
        end
    end

    assign sel = grant[1];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            rptr_d[c] = rptr_q[c];
            wptr_d[c] = wptr_q[c];
            cnt_d[c]  = cnt_q[c];
            if (flush_i) begin
                rptr_d[c] = '0;
                wptr_d[c] = '0;
                cnt_d[c]  = '0;
            end else begin
                if (push[c]) begin
                    wptr_d[c] = wptr_q[c] + PTR_WTH'(1);
                end
                if (grant[c]) begin
                    rptr_d[c] = rptr_q[c] + PTR_WTH'(1);
                end
                unique case ({push[c], grant[c]})
                    2'b10:   cnt_d[c] = cnt_q[c] + CNT_WTH'(1);
                    2'b01:   cnt_d[c] = cnt_q[c] - CNT_WTH'(1);
                    default: cnt_d[c] = cnt_q[c];
                endcase
            end
        end

        mdu_pri_d = mdu_pri_q;
        if (grant[0]) begin
            mdu_pri_d = 1'b0;
        end else if (grant[1]) begin
            mdu_pri_d = 1'b1;
        end

        wr_en_d   = |grant;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        if (|grant) begin
            wr_idx_d  = mem_idx[sel][rptr_q[sel]];
            wr_data_d = mem_data[sel][rptr_q[sel]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int c = 0; c < 2; c++) begin
                rptr_q[c] <= '0;
                wptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            mdu_pri_q <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                rptr_q[c] <= rptr_d[c];
                wptr_q[c] <= wptr_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            mdu_pri_q <= mdu_pri_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Queue storage is qualified by the counts, so it carries no reset.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                mem_idx[c][wptr_q[c]]  <= in_idx[c];
                mem_data[c][wptr_q[c]] <= in_data[c];
            end
        end
    end

    assign gpr_wr_en_o   = wr_en_q;
    assign gpr_wr_idx_o  = wr_idx_q;
    assign gpr_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_sy_ppl_gpr_wb_arb.sv
module tb_sy_ppl_gpr_wb_arb;

    localparam int DW = 64;
    localparam int IW = 7;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          m_valid, f_valid;
    logic          m_ready, f_ready;
    logic [IW-1:0] m_idx, f_idx;
    logic [DW-1:0] m_data, f_data;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [IW+DW-1:0] wr_log [$];

    sy_ppl_gpr_wb_arb #(
        .DWTH        (DW),
        .PHY_REG_WTH (IW),
        .FIFO_DEPTH  (2)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .flush_i        (flush),
        .mdu_wb_valid_i (m_valid),
        .mdu_wb_ready_o (m_ready),
        .mdu_wb_idx_i   (m_idx),
        .mdu_wb_data_i  (m_data),
        .fpu_wb_valid_i (f_valid),
        .fpu_wb_ready_o (f_ready),
        .fpu_wb_idx_i   (f_idx),
        .fpu_wb_data_i  (f_data),
        .gpr_wr_en_o    (wr_en),
        .gpr_wr_idx_o   (wr_idx),
        .gpr_wr_data_o  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write seen at the falling edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_log.push_back({wr_idx, wr_data});
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        flush   = 1'b0;
        m_valid = 1'b0; m_idx = '0; m_data = '0;
        f_valid = 1'b0; f_idx = '0; f_data = '0;
    endtask

    // Advance one cycle; returns at posedge + 1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_log(input string tag, input int idx, input logic [IW+DW-1:0] exp);
        logic [IW+DW-1:0] e;
        if (idx < wr_log.size()) e = wr_log[idx];
        else e = 'x;
        check(tag, e, exp);
    endtask

    logic [IW+DW-1:0] mq [$];
    logic [IW+DW-1:0] fq [$];
    logic             m_acc, f_acc;

    initial begin
        clear_inputs();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #3;
        // ---------------- reset values ----------------
        check("rst_en",      wr_en,   0);
        check("rst_idx",     wr_idx,  0);
        check("rst_data",    wr_data, 0);
        check("rst_m_ready", m_ready, 1);
        check("rst_f_ready", f_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // ---------------- single push, 2-cycle latency ----------------
        m_valid = 1'b1; m_idx = 7'd5; m_data = 64'hAA;
        @(negedge clk);
        check("single_ready", m_ready, 1);
        tick();
        clear_inputs();
        @(negedge clk);
        check("single_c1_en", wr_en, 0);
        tick();
        @(negedge clk);
        check("single_c2_en",   wr_en,   1);
        check("single_c2_idx",  wr_idx,  5);
        check("single_c2_data", wr_data, 64'hAA);
        tick();
        @(negedge clk);
        check("single_c3_en",   wr_en,   0);
        check("single_hold_idx",  wr_idx,  5);
        check("single_hold_data", wr_data, 64'hAA);
        tick();

        // ---------------- contention, round robin ----------------
        apply_reset();
        wr_log.delete();
        for (int r = 0; r < 2; r++) begin
            m_valid = 1'b1; m_idx = 7'd3; m_data = 64'h33;
            f_valid = 1'b1; f_idx = 7'd4; f_data = 64'h44;
            tick();
            idle(4);
        end
        check("cont_cnt", wr_log.size(), 4);
        check_log("cont_w0", 0, {7'd3, 64'h33});
        check_log("cont_w1", 1, {7'd4, 64'h44});
        check_log("cont_w2", 2, {7'd3, 64'h33});
        check_log("cont_w3", 3, {7'd4, 64'h44});

        // ---------------- full FIFO with back-pressure ----------------
        apply_reset();
        wr_log.delete();
        mq = '{{7'd10, 64'hA1}, {7'd11, 64'hA2}, {7'd12, 64'hA3}};
        fq = '{{7'd20, 64'hF1}, {7'd21, 64'hF2}, {7'd22, 64'hF3}};
        for (int cyc = 0; cyc < 10; cyc++) begin
            m_valid = (mq.size() != 0);
            f_valid = (fq.size() != 0);
            if (m_valid) {m_idx, m_data} = mq[0];
            if (f_valid) {f_idx, f_data} = fq[0];
            @(negedge clk);
            m_acc = m_valid && m_ready;
            f_acc = f_valid && f_ready;
            if (cyc == 2) begin
                check("full_c2_m_ready", m_ready, 1);
                check("full_c2_f_ready", f_ready, 0);
            end
            if (cyc == 3) check("full_c3_m_ready", m_ready, 0);
            tick();
            if (m_acc) void'(mq.pop_front());
            if (f_acc) void'(fq.pop_front());
        end
        clear_inputs();
        check("full_m_drained", mq.size(), 0);
        check("full_f_drained", fq.size(), 0);
        check("full_cnt", wr_log.size(), 6);
        check_log("full_w0", 0, {7'd10, 64'hA1});
        check_log("full_w1", 1, {7'd20, 64'hF1});
        check_log("full_w2", 2, {7'd11, 64'hA2});
        check_log("full_w3", 3, {7'd21, 64'hF2});
        check_log("full_w4", 4, {7'd12, 64'hA3});
        check_log("full_w5", 5, {7'd22, 64'hF3});

        // ---------------- x0 discard ----------------
        idle(2);
        wr_log.delete();
        f_valid = 1'b1; f_idx = 7'd0; f_data = 64'hDEAD;
        @(negedge clk);
        check("x0_ready", f_ready, 1);
        tick();
        idle(5);
        @(negedge clk);
        check("x0_no_write", wr_log.size(), 0);
        check("x0_ready_after", f_ready, 1);
        tick();

        // ---------------- flush ----------------
        apply_reset();
        wr_log.delete();
        m_valid = 1'b1; m_idx = 7'd30; m_data = 64'hC0;
        f_valid = 1'b1; f_idx = 7'd40; f_data = 64'hD0;
        tick();
        m_idx = 7'd31; m_data = 64'hC1;
        f_idx = 7'd41; f_data = 64'hD1;
        tick();
        clear_inputs();
        flush = 1'b1;
        m_valid = 1'b1; m_idx = 7'd32; m_data = 64'hC2;
        @(negedge clk);
        check("flush_m_ready", m_ready, 0);
        check("flush_f_ready", f_ready, 0);
        check("flush_c2_en",   wr_en,   1);
        check("flush_c2_idx",  wr_idx,  30);
        tick();
        clear_inputs();
        @(negedge clk);
        check("flush_post_m_ready", m_ready, 1);
        check("flush_post_f_ready", f_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("flush_post_en", wr_en, 0);
            tick();
            @(negedge clk);
        end
        tick();
        m_valid = 1'b1; m_idx = 7'd33; m_data = 64'hC3;
        tick();
        idle(4);
        check("flush_cnt", wr_log.size(), 2);
        check_log("flush_w0", 0, {7'd30, 64'hC0});
        check_log("flush_w1", 1, {7'd33, 64'hC3});

        // ---------------- asynchronous reset mid-transfer ----------------
        wr_log.delete();
        m_valid = 1'b1; m_idx = 7'd50; m_data = 64'hE0;
        f_valid = 1'b1; f_idx = 7'd60; f_data = 64'hF0;
        tick();
        f_valid = 1'b0;
        m_idx = 7'd51; m_data = 64'hE1;
        tick();
        clear_inputs();
        #2;
        check("arst_pre_en", wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("arst_en",      wr_en,   0);
        check("arst_idx",     wr_idx,  0);
        check("arst_data",    wr_data, 0);
        check("arst_m_ready", m_ready, 1);
        check("arst_f_ready", f_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);
        check("arst_no_stale", wr_log.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sy_ppl_gpr_wb_arb.md
SY_PPL_GPR_WB_ARB -- requirements
Module: sy_ppl_gpr_wb_arb

Interface
REQ-001 Parameter DWTH, default from sy_pkg (64): write-data width.
REQ-002 Parameter PHY_REG_WTH, default from sy_pkg (7): physical register index width.
REQ-003 Parameter FIFO_DEPTH, default 2: entries per channel queue; power of 2, at least 2.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 flush_i  input  1  pipeline flush; drops all queued results.
REQ-007 mdu_wb_valid_i / fpu_wb_valid_i  input  1 each  channel result valid.
REQ-008 mdu_wb_ready_o / fpu_wb_ready_o  output  1 each  channel can accept.
REQ-009 mdu_wb_idx_i / fpu_wb_idx_i  input  PHY_REG_WTH each  destination physical register.
REQ-010 mdu_wb_data_i / fpu_wb_data_i  input  DWTH each  result data.
REQ-011 gpr_wr_en_o  output  1  register-file write enable, one write per cycle.
REQ-012 gpr_wr_idx_o  output  PHY_REG_WTH  register-file write index.
REQ-013 gpr_wr_data_o  output  DWTH  register-file write data.

Function
REQ-014 Each channel SHALL own an independent FIFO_DEPTH-entry FIFO with read pointer, write pointer and occupancy counter; pointers wrap modulo FIFO_DEPTH.
REQ-015 A push SHALL occur when valid_i and ready_o are both high in the same cycle.
REQ-016 ready_o SHALL be high when the channel count is less than FIFO_DEPTH and flush_i is low.
REQ-017 ready_o SHALL depend on the registered count only. A pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-018 A push with idx equal to 0 SHALL be accepted and discarded. It SHALL NOT enter the FIFO and SHALL NOT cause a write.
REQ-019 Each cycle the arbiter SHALL grant at most one non-empty channel and pop its head entry.
REQ-020 If exactly one channel is non-empty, that channel SHALL be granted.
REQ-021 If both channels are non-empty, the arbiter SHALL grant the channel not granted last, using round-robin state rr_q. rr_q SHALL update only on a grant.
REQ-022 The granted head SHALL be registered into gpr_wr_en_o / gpr_wr_idx_o / gpr_wr_data_o. gpr_wr_en_o SHALL be low in any cycle with no grant.
REQ-023 Latency SHALL be 2 cycles: push in cycle t, grant in t+1 at the earliest, gpr_wr_en_o high in t+2.
REQ-024 Each channel SHALL preserve order: its entries are written in push order.
REQ-025 A push and a pop on the same channel in the same cycle SHALL leave the count unchanged.
REQ-026 The count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-027 flush_i high SHALL, on that edge, zero both counts and all pointers and force gpr_wr_en_o low in the next cycle. Pushes and grants in the flush cycle SHALL be ignored.
REQ-028 gpr_wr_idx_o and gpr_wr_data_o SHALL hold their last value while gpr_wr_en_o is low.

Reset
REQ-029 While rst_i is low, asynchronously: counts, pointers, gpr_wr_en_o, gpr_wr_idx_o and gpr_wr_data_o SHALL be 0, and rr_q SHALL favour MDU.
REQ-030 With reset asserted, both ready_o outputs SHALL read 1 (count 0, flush low). Reset mid-transfer SHALL discard all queued entries without issuing a write.
REQ-031 FIFO storage arrays need no reset.

Verification
REQ-032 Single push: mdu push idx=5, data=0xAA in cycle 0 -> cycle 2 gpr_wr_en_o=1, idx=5, data=0xAA; cycle 3 en=0.
REQ-033 Contention: mdu (idx 3) and fpu (idx 4) push in the same cycle after reset -> writes idx 3 then idx 4 on consecutive cycles; repeating the pair yields 3,4 again.
REQ-034 Full FIFO: 3 mdu pushes in consecutive cycles with fpu saturating the arbiter -> mdu_wb_ready_o=0 once the count reaches 2; no entry lost; mdu order preserved.
REQ-035 x0 discard: fpu push idx=0 -> ready stays high; no gpr_wr_en_o pulse within 4 cycles.
REQ-036 Flush: 2 entries queued in each channel, then flush_i pulse -> gpr_wr_en_o=0 from the cycle after flush; both ready_o=1; subsequent push writes normally.
REQ-037 Async reset: assert rst_i low mid-cycle with entries queued -> all outputs 0 immediately; after release no stale writes.
